// File: rtl/i2f_pkg.sv
// i2f_pkg: shared constants for the integer-to-binary32 converter.
// Rounding-mode encodings, exponent bias and datapath widths.
package i2f_pkg;

  localparam int INT_W  = 32;
  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam int BIAS   = 127;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

endpackage

// File: rtl/i2f_if.sv
// i2f_if: operand/result bundle for i2f_unit.
// master drives in_valid/d/rm(/is_unsigned), slave drives result+flags.
// is_unsigned exists only when I2F_UNSIGNED_EN is defined.
interface i2f_if;
  import i2f_pkg::*;

  logic              in_valid;
  logic [INT_W-1:0]  d;
`ifdef I2F_UNSIGNED_EN
  logic              is_unsigned;
`endif
  logic [2:0]        rm;
  logic              out_valid;
  logic [INT_W-1:0]  a;
  logic              invalid;
  logic              uf;
  logic              nx;

`ifdef I2F_UNSIGNED_EN
  modport master (
    output in_valid, d, is_unsigned, rm,
    input  out_valid, a, invalid, uf, nx
  );
  modport slave (
    input  in_valid, d, is_unsigned, rm,
    output out_valid, a, invalid, uf, nx
  );
`else
  modport master (
    output in_valid, d, rm,
    input  out_valid, a, invalid, uf, nx
  );
  modport slave (
    input  in_valid, d, rm,
    output out_valid, a, invalid, uf, nx
  );
`endif

endinterface

// File: rtl/i2f_unit_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
// Ports: x_i (operand), lz_o (count, 32 when x_i is zero).
module lzc32 (
  input  logic [31:0] x_i,
  output logic [5:0]  lz_o
);

  always_comb begin
    lz_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (x_i[i]) lz_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/i2f_unit.sv
// i2f_unit: FCVT.S.W (and FCVT.S.WU with I2F_UNSIGNED_EN) converter.
// Ports: clk, rst_n, io (i2f_if.slave); one registered output stage.
module i2f_unit
  import i2f_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  i2f_if.slave  io
);

  logic              sgn;
  logic [INT_W-1:0]  mag;
  logic [5:0]        lz;
  logic [INT_W-1:0]  shifted;
  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              inc;
  logic [MANT_W:0]   mant_sum;
  logic [EXP_W-1:0]  exp_w;
  logic [EXP_W-1:0]  exp_r;
  logic              nonzero;
  logic [INT_W-1:0]  a_d;
  logic              nx_d;

  logic              out_valid_q;
  logic [INT_W-1:0]  a_q;
  logic              nx_q;

`ifdef I2F_UNSIGNED_EN
  assign sgn = ~io.is_unsigned & io.d[INT_W-1];
`else
  assign sgn = io.d[INT_W-1];
`endif

  // Two's-complement negate; 0x80000000 maps onto itself.
  assign mag = sgn ? (~io.d + 32'd1) : io.d;

  lzc32 u_lzc (
    .x_i  (mag),
    .lz_o (lz)
  );

  assign shifted = mag << lz;
  // Hidden bit is set after normalization iff the operand is nonzero.
  assign nonzero = shifted[INT_W-1];
  assign mant    = shifted[30:8];
  assign guard   = shifted[7];
  assign sticky  = |shifted[6:0];
  assign lsb     = shifted[8];

  assign exp_w = EXP_W'(BIAS + INT_W - 1) - EXP_W'(lz);

  always_comb begin
    inc = 1'b0;
    unique case (1'b1)
      (io.rm == RM_RTZ): inc = 1'b0;
      (io.rm == RM_RDN): inc = sgn & (guard | sticky);
      (io.rm == RM_RUP): inc = ~sgn & (guard | sticky);
      (io.rm == RM_RMM): inc = guard;
      default:           inc = guard & (sticky | lsb);
    endcase
  end

  // Mantissa carry-out bumps the exponent; max result is 2^32.
  assign mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
  assign exp_r    = exp_w + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]};

  assign a_d  = nonzero ? {sgn, exp_r, mant_sum[MANT_W-1:0]} : '0;
  assign nx_d = guard | sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      nx_q        <= 1'b0;
    end else begin
      out_valid_q <= io.in_valid;
      if (io.in_valid) begin
        a_q  <= a_d;
        nx_q <= nx_d;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.a         = a_q;
  assign io.nx        = nx_q;
  assign io.invalid   = 1'b0;
  assign io.uf        = 1'b0;

endmodule

// File: tb/tb_i2f_unit.sv
// tb_i2f_unit: directed vectors with a queue scoreboard and
// a monitor that checks results, held outputs and reset behaviour.
module tb_i2f_unit;
  import i2f_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic        nx;
  } exp_t;

  logic clk;
  logic rst_n;
  i2f_if io ();

  i2f_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_a  = '0;
  logic        last_nx = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] dv, input logic [2:0] r,
                       input logic [31:0] ea, input logic enx);
    exp_t e;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.d        = dv;
    io.rm       = r;
`ifdef I2F_UNSIGNED_EN
    io.is_unsigned = 1'b0;
`endif
    e.a = ea; e.nx = enx;
    sb.push_back(e);
  endtask

`ifdef I2F_UNSIGNED_EN
  task automatic issue_u(input logic [31:0] dv, input logic [2:0] r,
                         input logic [31:0] ea, input logic enx);
    exp_t e;
    @(negedge clk);
    io.in_valid    = 1'b1;
    io.d           = dv;
    io.rm          = r;
    io.is_unsigned = 1'b1;
    e.a = ea; e.nx = enx;
    sb.push_back(e);
  endtask
`endif

  task automatic idle();
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      sb.delete();
      last_a  = '0;
      last_nx = 1'b0;
    end else if (io.out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected none", io.a);
      end else begin
        e = sb.pop_front();
        chk("result", io.a, e.a);
        chk("nx", {31'b0, io.nx}, {31'b0, e.nx});
        chk("nv_uf", {30'b0, io.invalid, io.uf}, 32'h0);
        last_a  = e.a;
        last_nx = e.nx;
      end
    end else begin
      chk("hold_a", io.a, last_a);
      chk("hold_nx", {31'b0, io.nx}, {31'b0, last_nx});
    end
  end

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b1;
    io.in_valid = 1'b0;
    io.d        = '0;
    io.rm       = RM_RNE;
`ifdef I2F_UNSIGNED_EN
    io.is_unsigned = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'b0, io.out_valid}, 32'h0);
    chk("rst_a", io.a, 32'h0);
    chk("rst_flags", {29'b0, io.invalid, io.uf, io.nx}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000_0010, RM_RNE, 32'h4180_0000, 1'b0);
    issue(32'hFFFF_FFF0, RM_RNE, 32'hC180_0000, 1'b0);
    issue(32'h1FFF_FFFF, RM_RNE, 32'h4E00_0000, 1'b1);
    issue(32'h1FFF_FFFF, RM_RTZ, 32'h4DFF_FFFF, 1'b1);
    issue(32'h8000_0000, RM_RNE, 32'hCF00_0000, 1'b0);
    issue(32'h0000_0000, RM_RNE, 32'h0000_0000, 1'b0);
    issue(32'h1FFF_FFFF, 3'b111, 32'h4E00_0000, 1'b1);
    issue(32'hE000_0001, RM_RDN, 32'hCE00_0000, 1'b1);
    issue(32'hE000_0001, RM_RUP, 32'hCDFF_FFFF, 1'b1);
    issue(32'h1FFF_FFFF, RM_RMM, 32'h4E00_0000, 1'b1);
    issue(32'h0100_0001, RM_RUP, 32'h4B80_0001, 1'b1);
    issue(32'h0100_0001, RM_RNE, 32'h4B80_0000, 1'b1);
    issue(32'h0100_0003, RM_RNE, 32'h4B80_0002, 1'b1);
    issue(32'h0000_0001, RM_RNE, 32'h3F80_0000, 1'b0);
    issue(32'h7FFF_FFFF, RM_RNE, 32'h4F00_0000, 1'b1);
    idle();
    idle();

    issue(32'h0000_0010, RM_RNE, 32'h4180_0000, 1'b0);
    issue(32'hFFFF_FFF0, RM_RNE, 32'hC180_0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, io.out_valid}, 32'h0);
    chk("async_rst_a", io.a, 32'h0);
    @(negedge clk);
    io.in_valid = 1'b0;
    rst_n = 1'b1;
    idle();

`ifdef I2F_UNSIGNED_EN
    issue_u(32'hFFFF_FFFF, RM_RNE, 32'h4F80_0000, 1'b1);
    issue_u(32'hFFFF_FFFF, RM_RTZ, 32'h4F7F_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, RM_RNE, 32'hBF80_0000, 1'b0);
    issue_u(32'h8000_0000, RM_RNE, 32'h4F00_0000, 1'b0);
`endif
    issue(32'h8000_0000, RM_RTZ, 32'hCF00_0000, 1'b0);
    issue(32'h0000_0010, RM_RUP, 32'h4180_0000, 1'b0);
    idle();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2f_unit.md
# i2f_unit

Integer-to-single-precision converter for the RISC-V F-extension datapath, implementing FCVT.S.W and optionally FCVT.S.WU. It converts a 32-bit integer operand to an IEEE-754 binary32 result and raises the fflags bits relevant to the conversion. It sits in the FPU execute stage as a single-cycle, fully pipelined unit with a registered output.

## Interface
Parameters:
- none; widths are fixed at 32 bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid; sampled on the clk rising edge.
- d  in  32  integer operand.
- is_unsigned  in  1  1 = treat d as unsigned (FCVT.S.WU). Present only with I2F_UNSIGNED_EN.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- out_valid  out  1  result valid.
- a  out  32  binary32 result.
- invalid  out  1  NV flag.
- uf  out  1  UF flag.
- nx  out  1  NX flag.

## Operation
- Sign:
  - Signed mode: sign = d[31], mag = |d| in 32 bits. 0x80000000 gives mag 0x80000000.
  - Unsigned mode: sign = 0, mag = d.
- Zero input: a = 0x00000000 (never −0), nx = 0.
- Normalization:
  - lz = leading-zero count of mag; shift mag left by lz.
  - Unbiased exponent e = 31 − lz; biased exponent = e + 127.
- Significand split:
  - mantissa = shifted[30:8] (hidden bit is shifted[31]).
  - guard = shifted[7]; sticky = OR(shifted[6:0]).
- Rounding increment:
  - RNE: guard & (sticky | lsb).
  - RTZ: 0.
  - RDN: sign & (guard | sticky).
  - RUP: ~sign & (guard | sticky).
  - RMM: guard.
- Increment carry: if the mantissa increment overflows, mantissa = 0 and exponent +1. Maximum result is 2^32 (0x4F800000), so the exponent never overflows.
- Flags:
  - nx = guard | sticky.
  - invalid = 0 always.
  - uf = 0 always. Integer conversion cannot produce NaN, overflow, underflow or subnormals.
- Output: a = {sign, exp[7:0], mantissa[22:0]}.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on a/flags at edge N+1, with out_valid = in_valid of edge N.
- Throughput is 1 conversion per cycle; there is no backpressure and no stall.
- When in_valid = 0, out_valid falls to 0 and a/flags hold their previous values.
- Reset (asynchronous, rst_n low): out_valid, a, invalid, uf, nx = 0 immediately.
  - Reset mid-operation discards the in-flight result.
  - The first valid result follows the first sampled in_valid after rst_n rises.

## Configuration
- I2F_UNSIGNED_EN defined: the is_unsigned port exists and unsigned conversion is supported.
- Undefined: the port is absent and all conversions are signed (FCVT.S.W only).

## Structure
- Package i2f_pkg holds:
  - rounding-mode localparams (RM_RNE … RM_RMM);
  - BIAS = 127;
  - widths (INT_W = 32, MANT_W = 23, EXP_W = 8).
- One sub-module, lzc32: a combinational 32-bit leading-zero counter with a 6-bit output (32 when input is zero).
- Everything else is combinational logic in i2f_unit feeding one output register stage.

## Test plan
- d = 0x00000010, signed, RNE → a = 0x41800000, nx = 0, invalid = 0, uf = 0.
- d = 0xFFFFFFF0 (−16), signed, RNE → a = 0xC1800000, nx = 0.
- d = 0x1FFFFFFF, RNE → a = 0x4E000000, nx = 1. Same d with RTZ → a = 0x4DFFFFFF, nx = 1.
- d = 0x80000000, signed → a = 0xCF000000, nx = 0. d = 0 → a = 0x00000000, nx = 0.
- With I2F_UNSIGNED_EN, d = 0xFFFFFFFF:
  - unsigned, RNE → a = 0x4F800000, nx = 1;
  - unsigned, RTZ → a = 0x4F7FFFFF;
  - signed → a = 0xBF800000, nx = 0.
- Back-to-back valid inputs every cycle produce results one cycle later in order. Asserting rst_n low mid-stream clears out_valid and a to 0 without waiting for a clock edge.
